// File: rtl/lcd_nibble_if.sv
// Byte-write handshake between the LCD sequencer and the nibble sender,
// together with the LCD data pins and E strobe driven by the sender.
interface lcd_nibble_if;
    logic       iWriteEnabler;
    logic [7:0] iData;
    logic       oWriteDone;
    logic [3:0] oNIBBLE;
    logic       oLCD_EN;

    modport master (
        output iWriteEnabler, iData,
        input  oWriteDone, oNIBBLE, oLCD_EN
    );

    modport slave (
        input  iWriteEnabler, iData,
        output oWriteDone, oNIBBLE, oLCD_EN
    );
endinterface

// File: rtl/lcd_nibble_sender.sv
// Sends one latched byte to the character LCD in 4-bit mode: upper nibble, then
// lower nibble, each framed by a timed E pulse, then waits out execution time.
//
// state     | meaning
// IDLE      | outputs low; latch byte when a write is requested
// HI_SETUP  | upper nibble on the bus, E low
// HI_PULSE  | upper nibble, E high
// HI_HOLD   | upper nibble held after E falls
// GAP       | inter-nibble gap
// LO_SETUP  | lower nibble on the bus, E low
// LO_PULSE  | lower nibble, E high
// LO_HOLD   | lower nibble held after E falls
// WAIT      | command execution time
// DONE      | single cycle; raises the done pulse
module lcd_nibble_sender #(
    parameter int unsigned SETUP_CYCLES      = 2,
    parameter int unsigned PULSE_CYCLES      = 12,
    parameter int unsigned HOLD_CYCLES       = 1,
    parameter int unsigned NIBBLE_GAP_CYCLES = 50,
    parameter int unsigned CMD_GAP_CYCLES    = 2000
) (
    input  logic         Clock,
    input  logic         Reset,
    lcd_nibble_if.slave  lcd
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_HI_SETUP, ST_HI_PULSE, ST_HI_HOLD, ST_GAP,
        ST_LO_SETUP, ST_LO_PULSE, ST_LO_HOLD, ST_WAIT, ST_DONE
    } state_t;

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(NIBBLE_GAP_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(CMD_GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [3:0]  nibble_q, nibble_d;
    logic        en_q, en_d;
    logic        done_q, done_d;
    logic [15:0] last;
    state_t      nxt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        byte_d  = byte_q;
        last    = 16'd0;
        nxt     = ST_IDLE;
        case (state_q)
            ST_HI_SETUP: begin last = SETUP_LAST; nxt = ST_HI_PULSE; end
            ST_HI_PULSE: begin last = PULSE_LAST; nxt = ST_HI_HOLD;  end
            ST_HI_HOLD:  begin last = HOLD_LAST;  nxt = ST_GAP;      end
            ST_GAP:      begin last = GAP_LAST;   nxt = ST_LO_SETUP; end
            ST_LO_SETUP: begin last = SETUP_LAST; nxt = ST_LO_PULSE; end
            ST_LO_PULSE: begin last = PULSE_LAST; nxt = ST_LO_HOLD;  end
            ST_LO_HOLD:  begin last = HOLD_LAST;  nxt = ST_WAIT;     end
            ST_WAIT:     begin last = WAIT_LAST;  nxt = ST_DONE;     end
            default:     begin last = 16'd0;      nxt = ST_IDLE;     end
        endcase

        if (state_q == ST_IDLE) begin
            cnt_d = 16'd0;
            if (lcd.iWriteEnabler) begin
                byte_d  = lcd.iData;
                state_d = ST_HI_SETUP;
            end
        end else if (cnt_q == last) begin
            state_d = nxt;
            cnt_d   = 16'd0;
        end
    end

    // Outputs are a registered decode of the current state, so they trail it by one cycle.
    always_comb begin
        nibble_d = 4'd0;
        en_d     = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_HI_SETUP, ST_HI_HOLD, ST_GAP:  nibble_d = byte_q[7:4];
            ST_HI_PULSE: begin nibble_d = byte_q[7:4]; en_d = 1'b1; end
            ST_LO_SETUP, ST_LO_HOLD, ST_WAIT: nibble_d = byte_q[3:0];
            ST_LO_PULSE: begin nibble_d = byte_q[3:0]; en_d = 1'b1; end
            ST_DONE:     begin nibble_d = byte_q[3:0]; done_d = 1'b1; end
            default:     nibble_d = 4'd0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            byte_q   <= 8'd0;
            nibble_q <= 4'd0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            nibble_q <= nibble_d;
            en_q     <= en_d;
            done_q   <= done_d;
        end
    end

    assign lcd.oNIBBLE    = nibble_q;
    assign lcd.oLCD_EN    = en_q;
    assign lcd.oWriteDone = done_q;

endmodule

// File: tb/tb_lcd_nibble_sender.sv
// Bench for lcd_nibble_sender: one DUT at default timing, one at reduced timing,
// checked against a cycle-offset waveform model derived from the timing rules.
module tb_lcd_nibble_sender;

    localparam int DS = 2, DP = 12, DH = 1, DG = 50, DC = 2000;
    localparam int RS = 1, RP = 2,  RH = 1, RG = 3,  RC = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       req   = 1'b0;
    logic       sel   = 1'b0;
    logic [7:0] data_r = 8'h00;

    always #5 Clock = ~Clock;

    lcd_nibble_if if0 ();
    lcd_nibble_if if1 ();

    assign if0.iWriteEnabler = req & ~sel;
    assign if0.iData         = data_r;
    assign if1.iWriteEnabler = req & sel;
    assign if1.iData         = data_r;

    lcd_nibble_sender dut_def (
        .Clock (Clock),
        .Reset (Reset),
        .lcd   (if0)
    );

    lcd_nibble_sender #(
        .SETUP_CYCLES      (RS),
        .PULSE_CYCLES      (RP),
        .HOLD_CYCLES       (RH),
        .NIBBLE_GAP_CYCLES (RG),
        .CMD_GAP_CYCLES    (RC)
    ) dut_red (
        .Clock (Clock),
        .Reset (Reset),
        .lcd   (if1)
    );

    logic [3:0] obs_nib;
    logic       obs_en, obs_done;
    assign obs_nib  = sel ? if1.oNIBBLE    : if0.oNIBBLE;
    assign obs_en   = sel ? if1.oLCD_EN    : if0.oLCD_EN;
    assign obs_done = sel ? if1.oWriteDone : if0.oWriteDone;

    int n_err = 0;
    int n_chk = 0;

    int r_mism, r_first_bad, r_pulses, r_done_cnt, r_done_at, r_wmin, r_wmax, w_cur;
    logic prev_en;
    logic [3:0] pnib [8];

    typedef struct {
        logic [7:0] data;
        int         drop_at;
        logic [7:0] d_after;
        int         change_at;
        logic [3:0] hi;
        logic [3:0] lo;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Expected {done, E, nibble} k cycles after the request-sampling edge.
    function automatic logic [5:0] model(input int k, input logic [7:0] d,
                                         input int S, input int P, input int H,
                                         input int G, input int C);
        int b, dk;
        logic [3:0] hi, lo;
        logic en, dn;
        logic [3:0] nib;
        hi = d[7:4];
        lo = d[3:0];
        b  = 1 + S + P + H + G;
        dk = b + S + P + H + C;
        nib = 4'd0; en = 1'b0; dn = 1'b0;
        if (k >= 1 && k < b) begin
            nib = hi;
            en  = (k >= 1 + S) && (k < 1 + S + P);
        end else if (k >= b && k <= dk) begin
            nib = lo;
            en  = (k >= b + S) && (k < b + S + P);
            dn  = (k == dk);
        end
        return {dn, en, nib};
    endfunction

    task automatic clear_track();
        r_mism = 0; r_first_bad = -1; r_pulses = 0; r_done_cnt = 0; r_done_at = -1;
        r_wmin = 1 << 30; r_wmax = 0; w_cur = 0; prev_en = 1'b0;
        for (int i = 0; i < 8; i++) pnib[i] = 4'd0;
    endtask

    task automatic observe(input int k, input logic [5:0] exp);
        if ({obs_done, obs_en, obs_nib} !== exp) begin
            if (r_mism == 0) r_first_bad = k;
            r_mism++;
        end
        if (obs_en) begin
            if (!prev_en) begin
                if (r_pulses < 8) pnib[r_pulses] = obs_nib;
                r_pulses++;
                w_cur = 0;
            end
            w_cur++;
        end else if (prev_en) begin
            if (w_cur < r_wmin) r_wmin = w_cur;
            if (w_cur > r_wmax) r_wmax = w_cur;
        end
        prev_en = obs_en;
        if (obs_done) begin
            r_done_cnt++;
            r_done_at = k;
        end
    endtask

    task automatic run_transfer(input logic [7:0] d, input int drop_at,
                                input logic [7:0] d_after, input int change_at,
                                input int extra);
        int S, P, H, G, C, last_k;
        S = sel ? RS : DS; P = sel ? RP : DP; H = sel ? RH : DH;
        G = sel ? RG : DG; C = sel ? RC : DC;
        last_k = 2 * (S + P + H) + G + C + 1 + extra;
        clear_track();
        data_r = d;
        req    = 1'b1;
        for (int k = 0; k <= last_k; k++) begin
            tick();
            observe(k, model(k, d, S, P, H, G, C));
            if (k == drop_at)   req    = 1'b0;
            if (k == change_at) data_r = d_after;
        end
        req = 1'b0;
    endtask

    initial begin
        int cnt;
        vecs[0] = '{8'h28, 0,    8'h00, 2000, 4'h2, 4'h8};
        vecs[1] = '{8'h28, 5,    8'hFF, 5,    4'h2, 4'h8};
        vecs[2] = '{8'hA5, 1000, 8'h3C, 300,  4'hA, 4'h5};
        vecs[3] = '{8'h01, 3,    8'h00, 70,   4'h0, 4'h1};

        // Reset state and quiet idle
        repeat (3) tick();
        check("reset_nibble", int'(obs_nib), 0);
        check("reset_en", int'(obs_en), 0);
        check("reset_done", int'(obs_done), 0);
        Reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (obs_nib != 4'd0 || obs_en || obs_done) cnt++;
        end
        check("idle_quiet_cycles", cnt, 0);

        // Table-driven single transfers at default timing
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_transfer(vecs[i].data, vecs[i].drop_at, vecs[i].d_after, vecs[i].change_at, 30);
            check($sformatf("vec%0d_wave_mism(first_bad=%0d)", i, r_first_bad), r_mism, 0);
            check($sformatf("vec%0d_hi_nibble", i), int'(pnib[0]), int'(vecs[i].hi));
            check($sformatf("vec%0d_lo_nibble", i), int'(pnib[1]), int'(vecs[i].lo));
            check($sformatf("vec%0d_e_pulses", i), r_pulses, 2);
            check($sformatf("vec%0d_done_count", i), r_done_cnt, 1);
            check($sformatf("vec%0d_done_at", i), r_done_at, 2081);
            check($sformatf("vec%0d_e_width_min", i), r_wmin, 12);
            check($sformatf("vec%0d_e_width_max", i), r_wmax, 12);
        end

        // Back-to-back: request held, new byte presented while done is high
        clear_track();
        data_r = 8'h48;
        req    = 1'b1;
        for (int k = 0; k <= 4163 + 5; k++) begin
            tick();
            if (k < 2082) observe(k, model(k, 8'h48, DS, DP, DH, DG, DC));
            else          observe(k, model(k - 2082, 8'h6F, DS, DP, DH, DG, DC));
            if (k == 2081) data_r = 8'h6F;
            if (k == 4163) req = 1'b0;
        end
        check($sformatf("b2b_wave_mism(first_bad=%0d)", r_first_bad), r_mism, 0);
        check("b2b_e_pulses", r_pulses, 4);
        check("b2b_nib0", int'(pnib[0]), 4);
        check("b2b_nib1", int'(pnib[1]), 8);
        check("b2b_nib2", int'(pnib[2]), 6);
        check("b2b_nib3", int'(pnib[3]), 15);
        check("b2b_done_count", r_done_cnt, 2);

        // Reset during the first E pulse
        data_r = 8'h28;
        req    = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            if (k == 0) req = 1'b0;
        end
        check("rst_e_high_before", int'(obs_en), 1);
        Reset = 1'b1;
        tick();
        check("rst_e_after", int'(obs_en), 0);
        check("rst_nibble_after", int'(obs_nib), 0);
        check("rst_done_after", int'(obs_done), 0);
        Reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 2100; k++) begin
            tick();
            if (obs_done || obs_en) cnt++;
        end
        check("rst_no_activity", cnt, 0);
        run_transfer(8'h28, 0, 8'h00, -1, 5);
        check($sformatf("post_rst_wave_mism(first_bad=%0d)", r_first_bad), r_mism, 0);
        check("post_rst_done_count", r_done_cnt, 1);

        // Random bytes, random release and data-change points, default timing
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d, d2;
            d  = 8'($urandom);
            d2 = 8'($urandom);
            run_transfer(d, int'($urandom_range(0, 2080)), d2, int'($urandom_range(0, 2080)), 5);
            check($sformatf("rand%0d_wave_mism(d=%02h first_bad=%0d)", i, d, r_first_bad), r_mism, 0);
            check($sformatf("rand%0d_done_count", i), r_done_cnt, 1);
        end

        // Reduced timing instance
        sel = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d, d2;
            d  = 8'($urandom);
            d2 = 8'($urandom);
            run_transfer(d, int'($urandom_range(0, 15)), d2, int'($urandom_range(0, 15)), 3);
            check($sformatf("red%0d_wave_mism(d=%02h first_bad=%0d)", i, d, r_first_bad), r_mism, 0);
            check($sformatf("red%0d_done_at", i), r_done_at, 16);
            check($sformatf("red%0d_e_width_min", i), r_wmin, 2);
            check($sformatf("red%0d_e_width_max", i), r_wmax, 2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
